// File: rtl/fp_pkg.sv
// fp_pkg: shared constants and types for the FP add/sub datapath
package fp_pkg;
    localparam int EXP_BITS  = 8;
    localparam int MANT_BITS = 23;
    localparam int BIAS      = 127;
    localparam int EXP_MAX   = 255;
    typedef enum logic [1:0] {IDLE, NORM, ROUND, HOLD} fp_state_t;
    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;
endpackage

// File: rtl/fp_round_rne.sv
// fp_round_rne: combinational round-to-nearest-even and packing of a normalized mantissa
module fp_round_rne #(
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23
) (
    input  logic [EXP_BITS:0]    exp,
    input  logic [MANT_BITS+3:0] mant,
    output logic [EXP_BITS-1:0]  exp_field,
    output logic [MANT_BITS-1:0] frac,
    output logic                 overflow,
    output logic                 inexact
);
    logic                 up;
    logic                 hidden;
    logic [MANT_BITS+1:0] sum;
    logic [EXP_BITS:0]    exp_post;
    assign up        = mant[2] & (mant[1] | mant[0] | mant[3]);
    assign sum       = {1'b0, mant[MANT_BITS+3:3]} + (MANT_BITS+2)'(up);
    // a carry out of the significand only happens from all-ones, so the low bits are already zero
    assign hidden    = sum[MANT_BITS+1] | sum[MANT_BITS];
    assign exp_post  = exp + (EXP_BITS+1)'(sum[MANT_BITS+1]);
    assign overflow  = exp_post >= {1'b0, {EXP_BITS{1'b1}}};
    assign exp_field = overflow ? '1 : hidden ? exp_post[EXP_BITS-1:0] : '0;
    assign frac      = overflow ? '0 : sum[MANT_BITS-1:0];
    assign inexact   = (|mant[2:0]) | overflow;
endmodule

// File: rtl/fp_norm_round_seq.sv
// fp_norm_round_seq: iterative normalize then RNE round stage with valid/ready handshake
module fp_norm_round_seq #(
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23,
    parameter int WIDTH     = 1 + EXP_BITS + MANT_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic [EXP_BITS-1:0]  in_exp,
    input  logic [MANT_BITS+3:0] in_mant,
    input  logic                 in_carry,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_result,
    output logic                 out_overflow,
    output logic                 out_underflow,
    output logic                 out_inexact
);
    import fp_pkg::*;
    localparam int M = MANT_BITS + 4;
    fp_state_t             state, state_n;
    fp_flags_t             flags;
    logic                  sign_r;
    logic [EXP_BITS:0]     exp_r;
    logic [M-1:0]          mant_r;
    logic                  norm_done;
    logic [EXP_BITS-1:0]   rnd_exp;
    logic [MANT_BITS-1:0]  rnd_frac;
    logic                  rnd_ovf, rnd_inx;
    assign in_ready      = state == IDLE && !rst;
    assign norm_done     = mant_r == '0 || mant_r[M-1] || exp_r == (EXP_BITS+1)'(1);
    assign out_overflow  = flags.overflow;
    assign out_underflow = flags.underflow;
    assign out_inexact   = flags.inexact;
    fp_round_rne #(.EXP_BITS(EXP_BITS), .MANT_BITS(MANT_BITS)) u_round (
        .exp       (exp_r),
        .mant      (mant_r),
        .exp_field (rnd_exp),
        .frac      (rnd_frac),
        .overflow  (rnd_ovf),
        .inexact   (rnd_inx)
    );
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = in_valid ? NORM : IDLE;
            NORM:    state_n = norm_done ? ROUND : NORM;
            ROUND:   state_n = HOLD;
            HOLD:    state_n = out_ready ? IDLE : HOLD;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_r     <= 1'b0;
            exp_r      <= '0;
            mant_r     <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            flags      <= '0;
        end else begin
            if (in_valid && in_ready) begin
                sign_r <= in_sign;
                exp_r  <= {1'b0, in_exp} + (EXP_BITS+1)'(in_carry);
                mant_r <= in_carry ? {1'b1, in_mant[M-1:2], in_mant[1] | in_mant[0]} : in_mant;
            end
            // sticky keeps its place in bit 0; the zero enters just above it
            if (state == NORM && !norm_done) begin
                mant_r <= {mant_r[M-2:1], 1'b0, mant_r[0]};
                exp_r  <= exp_r - 1'b1;
            end
            if (state == ROUND) begin
                out_result <= {sign_r, rnd_exp, rnd_frac};
                flags      <= {rnd_ovf, rnd_exp == '0 && rnd_inx, rnd_inx};
                out_valid  <= 1'b1;
            end
            if (state == HOLD && out_ready) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fp_norm_round_seq.sv
// tb_fp_norm_round_seq: directed checks of normalize/round results, flags, latency and handshake
module tb_fp_norm_round_seq;
    logic        clk, rst, in_valid, in_ready, in_sign, in_carry;
    logic [7:0]  in_exp;
    logic [26:0] in_mant;
    logic        out_valid, out_ready, out_overflow, out_underflow, out_inexact;
    logic [31:0] out_result;
    int          passed, total;

    fp_norm_round_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_carry(in_carry),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_overflow(out_overflow), .out_underflow(out_underflow), .out_inexact(out_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_op(input logic s, input logic [7:0] e, input logic [26:0] m,
                            input logic c, output int lat);
        @(negedge clk);
        in_sign = s; in_exp = e; in_mant = m; in_carry = c; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_sign = 1'b0; in_exp = 8'd0; in_mant = 27'd0; in_carry = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({out_valid, out_result, out_overflow, out_underflow, out_inexact, in_ready} !== 37'd0)
            $display("FAIL reset_outputs got valid=%b res=%h flags=%b%b%b ready=%b want all zero",
                     out_valid, out_result, out_overflow, out_underflow, out_inexact, in_ready);
        else passed++;
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", in_ready);
        else passed++;
    endtask

    task automatic test_carry();
        int lat;
        start_op(1'b0, 8'd127, 27'd0, 1'b1, lat);
        total++;
        if (lat !== 2) $display("FAIL carry_latency got %0d want 2", lat); else passed++;
        total++;
        if (out_result !== 32'h40000000) $display("FAIL carry_result got %h want 40000000", out_result);
        else passed++;
        total++;
        if ({out_overflow, out_underflow, out_inexact} !== 3'b000)
            $display("FAIL carry_flags got %b want 000", {out_overflow, out_underflow, out_inexact});
        else passed++;
        release_op();
    endtask

    task automatic test_cancel();
        int lat;
        start_op(1'b0, 8'd127, 27'h1000000, 1'b0, lat);
        total++;
        if (lat !== 4) $display("FAIL cancel_latency got %0d want 4", lat); else passed++;
        total++;
        if (out_result !== 32'h3E800000) $display("FAIL cancel_result got %h want 3e800000", out_result);
        else passed++;
        release_op();
    endtask

    task automatic test_rne();
        logic [26:0] mants [3] = '{27'h4000004, 27'h400000C, 27'h4000005};
        logic [31:0] exps  [3] = '{32'h3F800000, 32'h3F800002, 32'h3F800001};
        for (int i = 0; i < 3; i++) begin
            int lat;
            start_op(1'b0, 8'd127, mants[i], 1'b0, lat);
            total++;
            if (out_result !== exps[i])
                $display("FAIL rne_result[%0d] got %h want %h", i, out_result, exps[i]);
            else passed++;
            total++;
            if ({out_overflow, out_underflow, out_inexact} !== 3'b001)
                $display("FAIL rne_flags[%0d] got %b want 001", i, {out_overflow, out_underflow, out_inexact});
            else passed++;
            release_op();
        end
    endtask

    task automatic test_overflow();
        int lat;
        start_op(1'b0, 8'd254, 27'd0, 1'b1, lat);
        total++;
        if (out_result !== 32'h7F800000) $display("FAIL ovf_result got %h want 7f800000", out_result);
        else passed++;
        total++;
        if ({out_overflow, out_underflow, out_inexact} !== 3'b101)
            $display("FAIL ovf_flags got %b want 101", {out_overflow, out_underflow, out_inexact});
        else passed++;
        release_op();
    endtask

    task automatic test_subnormal();
        logic        sgn   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0]  e     [5] = '{8'd3, 8'd100, 8'd50, 8'd1, 8'd1};
        logic [26:0] m     [5] = '{27'h0800000, 27'h0, 27'h0, 27'h0000005, 27'h3FFFFFC};
        logic [31:0] res   [5] = '{32'h00400000, 32'h00000000, 32'h80000000, 32'h00000001, 32'h00800000};
        logic [2:0]  fl    [5] = '{3'b000, 3'b000, 3'b000, 3'b011, 3'b001};
        int          lats  [5] = '{4, 2, 2, 2, 2};
        for (int i = 0; i < 5; i++) begin
            int lat;
            start_op(sgn[i], e[i], m[i], 1'b0, lat);
            total++;
            if (out_result !== res[i])
                $display("FAIL sub_result[%0d] got %h want %h", i, out_result, res[i]);
            else passed++;
            total++;
            if ({out_overflow, out_underflow, out_inexact} !== fl[i])
                $display("FAIL sub_flags[%0d] got %b want %b", i, {out_overflow, out_underflow, out_inexact}, fl[i]);
            else passed++;
            total++;
            if (lat !== lats[i]) $display("FAIL sub_latency[%0d] got %0d want %0d", i, lat, lats[i]);
            else passed++;
            release_op();
        end
    endtask

    task automatic test_handshake();
        int lat;
        start_op(1'b0, 8'd127, 27'd0, 1'b1, lat);
        in_sign = 1'b1; in_exp = 8'd5; in_mant = 27'h1234567; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || out_result !== 32'h40000000 || in_ready !== 1'b0)
                $display("FAIL hold_stable[%0d] got valid=%b res=%h ready=%b want 1 40000000 0",
                         i, out_valid, out_result, in_ready);
            else passed++;
        end
        in_valid = 1'b0;
        release_op();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL hold_release got valid=%b ready=%b want 0 1", out_valid, in_ready);
        else passed++;
    endtask

    task automatic test_reset_midflight();
        int seen, lat;
        @(negedge clk);
        in_sign = 1'b0; in_exp = 8'd127; in_mant = 27'h1000000; in_carry = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL midrst_during got valid=%b ready=%b want 0 0", out_valid, in_ready);
        else passed++;
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", in_ready); else passed++;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        total++;
        if (seen !== 0) $display("FAIL midrst_no_output got %0d valid cycles want 0", seen); else passed++;
        start_op(1'b0, 8'd127, 27'd0, 1'b1, lat);
        total++;
        if (out_result !== 32'h40000000 || lat !== 2)
            $display("FAIL midrst_recover got %h lat %0d want 40000000 lat 2", out_result, lat);
        else passed++;
        release_op();
    endtask

    initial begin
        passed = 0;
        total = 0;
        test_reset();
        test_carry();
        test_cancel();
        test_rne();
        test_overflow();
        test_subnormal();
        test_handshake();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
